// File: rtl/osc_edge_counter_pkg.sv
// osc_edge_counter_pkg: shared state encoding and count-limit helper for the oscillator edge counter
package osc_edge_counter_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, FINISH} state_t;
  function automatic logic [63:0] cnt_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/osc_edge_counter_if.sv
// osc_edge_counter_if: start/done measurement handshake, oscillator input and result bus
interface osc_edge_counter_if #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 12
);
  logic              START;
  logic [GATE_W-1:0] GATE_LEN;
  logic              OSC_IN;
  logic              BUSY;
  logic              DONE;
  logic [CNT_W-1:0]  COUNT;
  logic              OVF;
  modport master (output START, GATE_LEN, OSC_IN, input BUSY, DONE, COUNT, OVF);
  modport slave  (input START, GATE_LEN, OSC_IN, output BUSY, DONE, COUNT, OVF);
endinterface

// File: rtl/osc_edge_counter_sync.sv
// osc_sync_edge: two-flop synchronizer plus history flop producing a one-cycle rising-edge strobe
module osc_sync_edge (
  input  logic CLK,
  input  logic RN,
  input  logic D,
  output logic EDGE
);
  logic [2:0] sh_q, sh_d;
  always_comb sh_d = {sh_q[1:0], D};
  always_ff @(posedge CLK or negedge RN)
    if (!RN) sh_q <= '0;
    else sh_q <= sh_d;
  assign EDGE = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/osc_edge_counter.sv
// osc_edge_counter: counts oscillator rising edges over a GATE_LEN+1 cycle window
// OSC_EDGE_CNT_SAT_EN selects a saturating accumulator; otherwise it wraps
module osc_edge_counter
  import osc_edge_counter_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 12
) (
  input logic CLK,
  input logic RN,
  osc_edge_counter_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  state_t            state_q, state_d;
  logic [GATE_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  acc_q, acc_d, count_q, count_d;
  logic              ovf_r_q, ovf_r_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic              edge_w, at_max;
  osc_sync_edge u_sync (.CLK(CLK), .RN(RN), .D(bus.OSC_IN), .EDGE(edge_w));
  assign at_max = acc_q == CNT_MAX;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    acc_d   = acc_q;
    ovf_r_d = ovf_r_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.START) begin
        state_d = COUNT;
        timer_d = bus.GATE_LEN;
        acc_d   = '0;
        ovf_r_d = 1'b0;
        busy_d  = 1'b1;
      end
      COUNT: begin
        if (edge_w) begin
`ifdef OSC_EDGE_CNT_SAT_EN
          acc_d = at_max ? acc_q : acc_q + 1'b1;
`else
          acc_d = acc_q + 1'b1;
`endif
          ovf_r_d = ovf_r_q | at_max;
        end
        state_d = (timer_q == '0) ? FINISH : COUNT;
        busy_d  = timer_q != '0;
        timer_d = (timer_q == '0) ? timer_q : timer_q - 1'b1;
      end
      FINISH: begin
        count_d = acc_q;
        ovf_d   = ovf_r_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RN)
    if (!RN) begin
      state_q <= IDLE;
      timer_q <= '0;
      acc_q   <= '0;
      ovf_r_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      acc_q   <= acc_d;
      ovf_r_q <= ovf_r_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.COUNT = count_q;
  assign bus.OVF   = ovf_q;
endmodule
